// File: rtl/ndn_spi_slave_if.sv
// rtl/ndn_spi_slave_if.sv - SPI wire pins plus the parallel RX/TX packet ports of the NDN link endpoint.
interface ndn_spi_slave_if #(
  parameter int META_W   = 8,
  parameter int PREFIX_W = 64,
  parameter int DATA_W   = 256
);
  logic                cs;
  logic                mosi;
  logic                miso;
  logic                RX_valid;
  logic [META_W-1:0]   packet_meta_data;
  logic [PREFIX_W-1:0] packet_prefix;
  logic [DATA_W-1:0]   packet_data;
  logic                TX_valid;
  logic                TX_ready;
  logic [META_W-1:0]   packet_meta_data_input;
  logic [PREFIX_W-1:0] packet_prefix_input;
  logic [DATA_W-1:0]   packet_data_input;

  modport slave (
    input  cs, mosi, TX_valid, packet_meta_data_input, packet_prefix_input, packet_data_input,
    output miso, RX_valid, packet_meta_data, packet_prefix, packet_data, TX_ready
  );

  modport master (
    output cs, mosi, TX_valid, packet_meta_data_input, packet_prefix_input, packet_data_input,
    input  miso, RX_valid, packet_meta_data, packet_prefix, packet_data, TX_ready
  );
endinterface

// File: rtl/ndn_spi_slave.sv
// rtl/ndn_spi_slave.sv - NDN SPI endpoint: independent mosi deserialiser and miso serialiser, one bit per clk.
// Optional packet counters enabled by defining NDN_SPI_PKT_CNT_EN.
module ndn_spi_slave #(
  parameter int META_W   = 8,
  parameter int PREFIX_W = 64,
  parameter int DATA_W   = 256
) (
  input  logic clk,
  input  logic rst,
  ndn_spi_slave_if.slave bus
`ifdef NDN_SPI_PKT_CNT_EN
  ,
  output logic [15:0] rx_pkt_count,
  output logic [15:0] tx_pkt_count
`endif
);
  localparam int MAX_W = (DATA_W > PREFIX_W) ? ((DATA_W > META_W) ? DATA_W : META_W)
                                             : ((PREFIX_W > META_W) ? PREFIX_W : META_W);
  localparam int CNT_W    = $clog2(MAX_W);
  localparam int TYPE_BIT = 6;

  typedef enum logic [1:0] {RX_IDLE, RX_META, RX_PREFIX, RX_DATA} rx_state_e;
  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_META, TX_PREFIX, TX_DATA} tx_state_e;

  rx_state_e           rx_state_q, rx_state_d;
  logic [CNT_W-1:0]    rx_cnt_q, rx_cnt_d;
  logic [META_W-1:0]   rx_meta_sr_q, rx_meta_sr_d;
  logic [PREFIX_W-1:0] rx_prefix_sr_q, rx_prefix_sr_d;
  logic [DATA_W-1:0]   rx_data_sr_q, rx_data_sr_d;
  logic                rx_done;
  logic                rx_valid_q;
  logic [META_W-1:0]   meta_out_q;
  logic [PREFIX_W-1:0] prefix_out_q;
  logic [DATA_W-1:0]   data_out_q;

  tx_state_e           tx_state_q, tx_state_d;
  logic [CNT_W-1:0]    tx_cnt_q, tx_cnt_d;
  logic [META_W-1:0]   tx_meta_sr_q, tx_meta_sr_d;
  logic [PREFIX_W-1:0] tx_prefix_sr_q, tx_prefix_sr_d;
  logic [DATA_W-1:0]   tx_data_sr_q, tx_data_sr_d;
  logic                tx_int_q, tx_int_d;
  logic                miso_q, miso_d;
  logic                tx_last;

  // The completing edge is also the one that samples the final bit, so outputs take the _d shift values.
  always_comb begin
    rx_state_d     = rx_state_q;
    rx_cnt_d       = rx_cnt_q;
    rx_meta_sr_d   = rx_meta_sr_q;
    rx_prefix_sr_d = rx_prefix_sr_q;
    rx_data_sr_d   = rx_data_sr_q;
    rx_done        = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (!bus.mosi) begin
          rx_state_d = RX_META;
          rx_cnt_d   = CNT_W'(META_W - 1);
        end
      end
      RX_META: begin
        rx_meta_sr_d = {rx_meta_sr_q[META_W-2:0], bus.mosi};
        rx_cnt_d     = rx_cnt_q - 1'b1;
        if (rx_cnt_q == '0) begin
          rx_state_d = RX_PREFIX;
          rx_cnt_d   = CNT_W'(PREFIX_W - 1);
        end
      end
      RX_PREFIX: begin
        rx_prefix_sr_d = {rx_prefix_sr_q[PREFIX_W-2:0], bus.mosi};
        rx_cnt_d       = rx_cnt_q - 1'b1;
        if (rx_cnt_q == '0) begin
          if (rx_meta_sr_q[TYPE_BIT]) begin
            rx_state_d = RX_IDLE;
            rx_done    = 1'b1;
          end else begin
            rx_state_d = RX_DATA;
            rx_cnt_d   = CNT_W'(DATA_W - 1);
          end
        end
      end
      RX_DATA: begin
        rx_data_sr_d = {rx_data_sr_q[DATA_W-2:0], bus.mosi};
        rx_cnt_d     = rx_cnt_q - 1'b1;
        if (rx_cnt_q == '0) begin
          rx_state_d = RX_IDLE;
          rx_done    = 1'b1;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
    if (bus.cs) begin
      rx_state_d = RX_IDLE;
      rx_done    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_state_q     <= RX_IDLE;
      rx_cnt_q       <= '0;
      rx_meta_sr_q   <= '0;
      rx_prefix_sr_q <= '0;
      rx_data_sr_q   <= '0;
      rx_valid_q     <= 1'b0;
      meta_out_q     <= '0;
      prefix_out_q   <= '0;
      data_out_q     <= '0;
    end else begin
      rx_state_q     <= rx_state_d;
      rx_cnt_q       <= rx_cnt_d;
      rx_meta_sr_q   <= rx_meta_sr_d;
      rx_prefix_sr_q <= rx_prefix_sr_d;
      rx_data_sr_q   <= rx_data_sr_d;
      rx_valid_q     <= rx_done;
      if (rx_done) begin
        meta_out_q   <= rx_meta_sr_q;
        prefix_out_q <= rx_prefix_sr_d;
        data_out_q   <= rx_meta_sr_q[TYPE_BIT] ? '0 : rx_data_sr_d;
      end
    end
  end

  // miso is registered: each edge drives the MSB of the active field, and START already emits meta MSB.
  always_comb begin
    tx_state_d     = tx_state_q;
    tx_cnt_d       = tx_cnt_q;
    tx_meta_sr_d   = tx_meta_sr_q;
    tx_prefix_sr_d = tx_prefix_sr_q;
    tx_data_sr_d   = tx_data_sr_q;
    tx_int_d       = tx_int_q;
    miso_d         = miso_q;
    tx_last        = 1'b0;
    case (tx_state_q)
      TX_IDLE: begin
        miso_d = 1'b1;
        if (bus.TX_valid) begin
          tx_state_d     = TX_START;
          tx_meta_sr_d   = bus.packet_meta_data_input;
          tx_prefix_sr_d = bus.packet_prefix_input;
          tx_data_sr_d   = bus.packet_data_input;
          tx_int_d       = bus.packet_meta_data_input[TYPE_BIT];
          miso_d         = 1'b0;
        end
      end
      TX_START: begin
        miso_d       = tx_meta_sr_q[META_W-1];
        tx_meta_sr_d = {tx_meta_sr_q[META_W-2:0], 1'b0};
        tx_state_d   = TX_META;
        tx_cnt_d     = CNT_W'(META_W - 2);
      end
      TX_META: begin
        miso_d       = tx_meta_sr_q[META_W-1];
        tx_meta_sr_d = {tx_meta_sr_q[META_W-2:0], 1'b0};
        tx_cnt_d     = tx_cnt_q - 1'b1;
        if (tx_cnt_q == '0) begin
          tx_state_d = TX_PREFIX;
          tx_cnt_d   = CNT_W'(PREFIX_W - 1);
        end
      end
      TX_PREFIX: begin
        miso_d         = tx_prefix_sr_q[PREFIX_W-1];
        tx_prefix_sr_d = {tx_prefix_sr_q[PREFIX_W-2:0], 1'b0};
        tx_cnt_d       = tx_cnt_q - 1'b1;
        if (tx_cnt_q == '0) begin
          if (tx_int_q) begin
            tx_state_d = TX_IDLE;
            tx_last    = 1'b1;
          end else begin
            tx_state_d = TX_DATA;
            tx_cnt_d   = CNT_W'(DATA_W - 1);
          end
        end
      end
      TX_DATA: begin
        miso_d       = tx_data_sr_q[DATA_W-1];
        tx_data_sr_d = {tx_data_sr_q[DATA_W-2:0], 1'b0};
        tx_cnt_d     = tx_cnt_q - 1'b1;
        if (tx_cnt_q == '0) begin
          tx_state_d = TX_IDLE;
          tx_last    = 1'b1;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
    if (bus.cs) begin
      tx_state_d = TX_IDLE;
      miso_d     = 1'b1;
      tx_last    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      tx_state_q     <= TX_IDLE;
      tx_cnt_q       <= '0;
      tx_meta_sr_q   <= '0;
      tx_prefix_sr_q <= '0;
      tx_data_sr_q   <= '0;
      tx_int_q       <= 1'b0;
      miso_q         <= 1'b1;
    end else begin
      tx_state_q     <= tx_state_d;
      tx_cnt_q       <= tx_cnt_d;
      tx_meta_sr_q   <= tx_meta_sr_d;
      tx_prefix_sr_q <= tx_prefix_sr_d;
      tx_data_sr_q   <= tx_data_sr_d;
      tx_int_q       <= tx_int_d;
      miso_q         <= miso_d;
    end
  end

  assign bus.miso             = miso_q;
  assign bus.TX_ready         = (tx_state_q == TX_IDLE);
  assign bus.RX_valid         = rx_valid_q;
  assign bus.packet_meta_data = meta_out_q;
  assign bus.packet_prefix    = prefix_out_q;
  assign bus.packet_data      = data_out_q;

`ifdef NDN_SPI_PKT_CNT_EN
  logic [15:0] rx_pkt_cnt_q, tx_pkt_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_pkt_cnt_q <= '0;
      tx_pkt_cnt_q <= '0;
    end else begin
      if (rx_done) rx_pkt_cnt_q <= rx_pkt_cnt_q + 16'd1;
      if (tx_last) tx_pkt_cnt_q <= tx_pkt_cnt_q + 16'd1;
    end
  end

  assign rx_pkt_count = rx_pkt_cnt_q;
  assign tx_pkt_count = tx_pkt_cnt_q;
`endif
endmodule
